// File: rtl/mips150_lsu_pkg.sv
// Shared types, region bit positions and lane helpers for the MIPS150 load/store unit.
package mips150_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_IO_REQ  = 2'b01,
        ST_IO_WAIT = 2'b10,
        ST_DONE    = 2'b11
    } state_e;

    localparam int IO_BIT   = 31;
    localparam int IMEM_BIT = 29;
    localparam int DMEM_BIT = 28;

    // Physical byte lane (lane 0 = data[7:0]) holding the addressed byte.
    function automatic logic [1:0] byte_lane(input logic [1:0] lo, input bit big_endian);
        byte_lane = big_endian ? ~lo : lo;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = lo[0];
            default: is_misaligned = (lo != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lo,
                                                input bit big_endian);
        logic [1:0] lane;
        lane = byte_lane(lo, big_endian);
        case (size)
            SZ_BYTE: byte_enables = 4'b0001 << lane;
            SZ_HALF: byte_enables = lane[1] ? 4'b1100 : 4'b0011;
            default: byte_enables = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: replicate = {4{wdata[7:0]}};
            SZ_HALF: replicate = {2{wdata[15:0]}};
            default: replicate = wdata;
        endcase
    endfunction

endpackage

// File: rtl/mips150_load_align.sv
// Combinational load extraction: picks the addressed byte/half from a memory word and extends it.
module mips150_load_align
    import mips150_lsu_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [1:0]  lane_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select followed by sign/zero extension.
    always_comb begin
        lane_s = byte_lane(addr_lo, BIG_ENDIAN);
        byte_s = rdata[{lane_s, 3'b000} +: 8];
        half_s = lane_s[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: data = {{24{sign_ext & byte_s[7]}}, byte_s};
            SZ_HALF: data = {{16{sign_ext & half_s[15]}}, half_s};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mips150_lsu.sv
// MIPS150 load/store unit: DMEM/IMEM access issued from X, IO bus handled by a small
// handshake FSM that stalls X until the IO op completes.
module mips150_lsu
    import mips150_lsu_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int IO_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              lsu_stall,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              misalign,
    output logic              io_timeout,
    output logic [3:0]        dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    output logic [3:0]        imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              io_req_valid,
    input  logic              io_req_ready,
    output logic              io_we,
    output logic [3:0]        io_be,
    output logic [31:0]       io_addr,
    output logic [31:0]       io_wdata,
    input  logic              io_resp_valid,
    input  logic [31:0]       io_rdata
);

    localparam int TO_W = (IO_TIMEOUT < 2) ? 1 : $clog2(IO_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(IO_TIMEOUT - 1);

    state_e          state_r;
    logic [TO_W-1:0] to_cnt_r;
    logic [4:0]      io_rd_r;
    logic [1:0]      io_lo_r;
    logic [1:0]      io_size_r;
    logic            io_sgn_r;
    logic [31:0]     io_data_r;
    logic [1:0]      ld_lo_r;
    logic [1:0]      ld_size_r;
    logic            ld_sgn_r;
    logic            wb_dmem_r;

    logic            is_io_s;
    logic            mis_s;
    logic            live_s;
    logic            to_hit_s;
    logic [3:0]      be_s;
    logic [31:0]     wrep_s;
    logic [31:0]     dmem_ext_s;
    logic [31:0]     io_ext_s;

    assign is_io_s  = req_addr[IO_BIT];
    assign mis_s    = is_misaligned(req_size, req_addr[1:0]);
    assign be_s     = byte_enables(req_size, req_addr[1:0], BIG_ENDIAN);
    assign wrep_s   = replicate(req_size, req_wdata);
    assign to_hit_s = (IO_TIMEOUT != 0) && (to_cnt_r == TO_LIMIT);

    // Memory accesses only leave in IDLE; in DONE the held X request is an IO op being retired.
    assign live_s     = req_valid & (state_r == ST_IDLE) & ~rst & ~mis_s & ~is_io_s;
    assign dmem_we    = (live_s & req_we & req_addr[DMEM_BIT]) ? be_s : 4'b0000;
    assign imem_we    = (live_s & req_we & req_addr[IMEM_BIT]) ? be_s : 4'b0000;
    assign dmem_addr  = req_addr[ADDR_W+1:2];
    assign imem_addr  = req_addr[ADDR_W+1:2];
    assign dmem_wdata = wrep_s;
    assign imem_wdata = wrep_s;

    assign lsu_stall = (state_r == ST_IO_REQ) | (state_r == ST_IO_WAIT) |
                       ((state_r == ST_IDLE) & req_valid & is_io_s & ~mis_s);

    // DMEM data arrives one cycle after the request, so it is aligned on the way out.
    assign wb_data = wb_dmem_r ? dmem_ext_s : io_data_r;

    mips150_load_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_dmem_align (
        .rdata    (dmem_rdata),
        .addr_lo  (ld_lo_r),
        .size     (ld_size_r),
        .sign_ext (ld_sgn_r),
        .data     (dmem_ext_s)
    );

    mips150_load_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_io_align (
        .rdata    (io_rdata),
        .addr_lo  (io_lo_r),
        .size     (io_size_r),
        .sign_ext (io_sgn_r),
        .data     (io_ext_s)
    );

    // IO handshake FSM, write-back and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            to_cnt_r     <= '0;
            io_req_valid <= 1'b0;
            io_we        <= 1'b0;
            io_be        <= 4'b0000;
            io_addr      <= 32'h0000_0000;
            io_wdata     <= 32'h0000_0000;
            io_rd_r      <= 5'd0;
            io_lo_r      <= 2'b00;
            io_size_r    <= 2'b00;
            io_sgn_r     <= 1'b0;
            io_data_r    <= 32'h0000_0000;
            ld_lo_r      <= 2'b00;
            ld_size_r    <= 2'b00;
            ld_sgn_r     <= 1'b0;
            wb_dmem_r    <= 1'b0;
            wb_valid     <= 1'b0;
            wb_rd        <= 5'd0;
            misalign     <= 1'b0;
            io_timeout   <= 1'b0;
        end else begin
            wb_valid   <= 1'b0;
            misalign   <= 1'b0;
            io_timeout <= 1'b0;
            if (to_cnt_r != {TO_W{1'b1}}) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end else begin
                to_cnt_r <= to_cnt_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && mis_s) begin
                        misalign <= 1'b1;
                    end else if (req_valid && is_io_s) begin
                        io_req_valid <= 1'b1;
                        io_we        <= req_we;
                        io_be        <= be_s;
                        io_addr      <= req_addr;
                        io_wdata     <= wrep_s;
                        io_rd_r      <= req_rd;
                        io_lo_r      <= req_addr[1:0];
                        io_size_r    <= req_size;
                        io_sgn_r     <= req_signed;
                        to_cnt_r     <= '0;
                        state_r      <= ST_IO_REQ;
                    end else if (req_valid && !req_we) begin
                        wb_valid  <= 1'b1;
                        wb_rd     <= req_rd;
                        wb_dmem_r <= 1'b1;
                        ld_lo_r   <= req_addr[1:0];
                        ld_size_r <= req_size;
                        ld_sgn_r  <= req_signed;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_IO_REQ: begin
                    if (io_req_ready) begin
                        io_req_valid <= 1'b0;
                        to_cnt_r     <= '0;
                        state_r      <= io_we ? ST_DONE : ST_IO_WAIT;
                    end else if (to_hit_s) begin
                        io_req_valid <= 1'b0;
                        io_timeout   <= 1'b1;
                        io_data_r    <= 32'h0000_0000;
                        to_cnt_r     <= '0;
                        state_r      <= ST_DONE;
                    end else begin
                        state_r <= ST_IO_REQ;
                    end
                end
                ST_IO_WAIT: begin
                    if (io_resp_valid) begin
                        io_data_r <= io_ext_s;
                        to_cnt_r  <= '0;
                        state_r   <= ST_DONE;
                    end else if (to_hit_s) begin
                        io_timeout <= 1'b1;
                        io_data_r  <= 32'h0000_0000;
                        to_cnt_r   <= '0;
                        state_r    <= ST_DONE;
                    end else begin
                        state_r <= ST_IO_WAIT;
                    end
                end
                ST_DONE: begin
                    to_cnt_r <= '0;
                    state_r  <= ST_IDLE;
                    if (!io_we) begin
                        wb_valid  <= 1'b1;
                        wb_rd     <= io_rd_r;
                        wb_dmem_r <= 1'b0;
                    end else begin
                        wb_dmem_r <= wb_dmem_r;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mips150_lsu.md
# mips150_lsu

Parametrised load/store unit for the MIPS150 pipeline, replacing the inline store-mask, memory-map and load-extraction logic of the 3-stage datapath. It takes one memory request per cycle from the X stage and drives the synchronous DMEM, the IMEM write port, and a variable-latency IO bus over a valid/ready handshake. It delivers sign- or zero-extended load data to write-back one cycle after the request leaves X. Misaligned accesses are flagged, IO timeouts are detected, endianness is configurable, and the pipeline is stalled while IO is outstanding.

## Interface
- ADDR_W, 12: word-address width of DMEM/IMEM ports (byte address bits [ADDR_W+1:2]).
- BIG_ENDIAN, 1: 1 → byte 0 at data[31:24]; 0 → byte 0 at data[7:0].
- IO_TIMEOUT, 255: max cycles waiting in IO_REQ or IO_WAIT; 0 disables timeout.
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  X-stage memory op present.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 illegal, treated as word.
- req_signed  in  1  sign-extend loads (LB/LH).
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data, right-justified.
- req_rd  in  5  load destination register.
- lsu_stall  out  1  hold X stage.
- wb_valid  out  1  load result valid.
- wb_rd  out  5  destination register.
- wb_data  out  32  extended load data.
- misalign  out  1  one-cycle pulse.
- io_timeout  out  1  one-cycle pulse.
- dmem_we  out  4  byte write enables, bit 3 = data[31:24].
- dmem_addr  out  ADDR_W  DMEM word address.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_rdata  in  32  DMEM read data, 1-cycle latency.
- imem_we  out  4  IMEM write enables.
- imem_addr  out  ADDR_W  IMEM word address.
- imem_wdata  out  32  IMEM write data.
- io_req_valid  out  1  IO request valid.
- io_req_ready  in  1  IO request ready.
- io_we  out  1  IO write.
- io_be  out  4  IO byte enables.
- io_addr  out  32  IO byte address.
- io_wdata  out  32  IO write data.
- io_resp_valid  in  1  IO load response.
- io_rdata  in  32  IO load data.

## Operation
- Region decode:
  - addr[31] = 1 → IO.
  - Otherwise a store writes DMEM if addr[28] and IMEM if addr[29]; both may be written.
  - A non-IO load always reads DMEM.
- Byte enables:
  - Byte access: one-hot lane selected by addr[1:0].
  - Half access: lane pair selected by addr[1].
  - Word access: 4'b1111.
  - Write data is replicated across lanes (byte ×4, half ×2).
- Misalignment: a half access with addr[0] = 1, or a word access with addr[1:0] ≠ 0.
  - No enables are driven and no wb is produced.
  - misalign pulses the next cycle.
- FSM states: IDLE, IO_REQ, IO_WAIT, DONE.
  - IDLE → IO_REQ on accepting an IO request. io_* outputs are registered from the request.
  - IO_REQ → DONE on io_req_ready for a store.
  - IO_REQ → IO_WAIT on io_req_ready for a load.
  - IO_WAIT → DONE on io_resp_valid; io_rdata is captured.
  - DONE → IDLE unconditionally.
  - Timeout: after IO_TIMEOUT cycles in IO_REQ or IO_WAIT → DONE, with data = 0 and io_timeout pulsed.
- lsu_stall = (state ∈ {IO_REQ, IO_WAIT}) | (state == IDLE & req_valid & IO region & !misaligned).
- In DONE, the held request is consumed, not re-issued.
- io_resp_valid in any state other than IO_WAIT is ignored.

## Timing
- A DMEM/IMEM access is issued combinationally in X cycle T. For loads, wb_valid, wb_rd and wb_data are valid at T+1, with no stall.
- IO: io_req_valid is high from T+1 until the handshake. The DONE cycle is the X cycle the op leaves; wb follows in the next cycle.
- Reset values:
  - state = IDLE.
  - All enables, wb_valid, misalign, io_timeout and io_req_valid = 0.
  - wb_data = 0, wb_rd = 0.
  - Timeout counter = 0.
- Reset mid-operation: the outstanding IO request is abandoned, any pending wb is dropped, and lsu_stall falls in the cycle after rst.
- The timeout counter saturates and clears on every state entry.

## Structure
- Package mips150_lsu_pkg holds:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD);
  - FSM state enum;
  - region bit positions (IO_BIT = 31, IMEM_BIT = 29, DMEM_BIT = 28).
- Sub-module mips150_load_align is purely combinational. It takes rdata, addr[1:0], size, signed and BIG_ENDIAN, and produces the extended word. It is used on both the DMEM and IO return paths.

## Test plan
- SB 0xAB to 0x1000_0003 with BIG_ENDIAN = 1 → dmem_we = 4'b0001, dmem_wdata = 0xABABABAB, no stall.
- LH signed from 0x1000_0002 with dmem_rdata = 0x1234_8001 → wb_data = 0xFFFF_8001 at T+1; with req_signed = 0 → 0x0000_8001.
- LW from 0x8000_0010; io_req_ready after 3 cycles and io_resp_valid 2 cycles later with 0xDEAD_BEEF → lsu_stall high throughout, one DONE cycle, then wb_data = 0xDEADBEEF; no duplicate io_req.
- SW to 0x3000_0004 → dmem_we = imem_we = 4'b1111, both addresses = 1. LW from 0x1000_0002 → misalign pulse, no enables, no wb.
- IO load with no response, IO_TIMEOUT = 4 → io_timeout pulse, wb_data = 0, FSM back in IDLE.
- rst asserted during IO_WAIT → io_req_valid = 0 and state IDLE the next cycle; a late io_resp_valid produces no wb.
